// File: rtl/fifo_4bit_bus.sv
// Synchronous FIFO buffering words ahead of a bus register; dout/dout_valid drive its d/en.
// Occupancy, full/empty and sticky overflow/underflow flags are all held in flops.
module fifo_4bit_bus #(
    parameter  int unsigned WIDTH = 4,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             full,
    output logic             empty,
    output logic [CNTW-1:0]  count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned PTRW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW-1:0]  rd_ptr;
    logic             push_ok;
    logic             pop_ok;
    logic [CNTW-1:0]  count_nxt;

    // Acceptance depends only on registered flags, so no wr_en/rd_en path reaches full/empty
    assign push_ok = wr_en && !full;
    assign pop_ok  = rd_en && !empty;

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop_ok) begin
            count_nxt = count + CNTW'(1);
        end else if (pop_ok && !push_ok) begin
            count_nxt = count - CNTW'(1);
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            count      <= count_nxt;
            full       <= (count_nxt == CNTW'(DEPTH));
            empty      <= (count_nxt == CNTW'(0));
            dout_valid <= pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTRW'(1);
            end
            if (pop_ok) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTRW'(1);
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule
